// File: rtl/mcu_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// mcu_cmd_ctrl
//
// Command router for bytes received from the MCU over SPI. The first byte of
// each frame selects a target (1=HID, 2=OSD, 3=SYS, 4=SDC); every following
// byte is forwarded to that target as a one-cycle strobe. The first forwarded
// byte (the command byte) is also flagged on tgt_start. Frames with an
// unknown target id are consumed silently and counted in err_cnt. A frame
// that stays idle for TIMEOUT cycles is aborted: the remaining bytes are
// dropped until frame falls.
//
// Build option:
//   MCU_CMD_SDC_EN  when defined, target id 4 routes to tgt_strobe[3];
//                   otherwise id 4 is an unknown id and bit 3 is tied low.
//
// Parameters:
//   TIMEOUT     idle cycles inside an open frame before the frame is aborted
//   ERR_W       width of the saturating unknown-target error counter
//
// Ports:
//   clk         core clock, rising edge
//   reset_n     asynchronous active-low reset
//   frame       high while an MCU SPI frame is open
//   in_strobe   one-cycle pulse, in_data holds a new received byte
//   in_data     received byte
//   tgt_strobe  one-hot byte strobe per target (bit n = target id n+1)
//   tgt_start   one-hot pulse alongside tgt_strobe for the command byte
//   tgt_data    byte presented to the selected target
//   tgt_reply   reply bytes from the targets, byte n belongs to target bit n
//   reply_data  next byte to be shifted back to the MCU
//   busy        high while the controller is not idle
//   err_cnt     saturating count of frames with an unknown target id
// -----------------------------------------------------------------------------
module mcu_cmd_ctrl #(
   parameter logic [15:0] TIMEOUT = 16'd50000,
   parameter int unsigned ERR_W   = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             frame,
   input  logic             in_strobe,
   input  logic [7:0]       in_data,
   output logic [3:0]       tgt_strobe,
   output logic [3:0]       tgt_start,
   output logic [7:0]       tgt_data,
   input  logic [31:0]      tgt_reply,
   output logic [7:0]       reply_data,
   output logic             busy,
   output logic [ERR_W-1:0] err_cnt
);

   typedef enum logic [1:0] {
      StIdle,
      StTarget,
      StRoute,
      StDiscard
   } state_e;

`ifdef MCU_CMD_SDC_EN
   localparam logic [3:0] TgtMask = 4'b1111;
`else
   localparam logic [3:0] TgtMask = 4'b0111;
`endif

   localparam logic [ERR_W-1:0] ErrMax = {ERR_W{1'b1}};

   state_e           state_q, state_d;
   logic             frame_q;
   logic [1:0]       sel_q, sel_d;
   logic [7:0]       byte_cnt_q, byte_cnt_d;
   logic [15:0]      timer_q, timer_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [3:0]       strobe_q, strobe_d;
   logic [3:0]       start_q, start_d;
   logic [7:0]       data_q, data_d;
   logic [7:0]       reply_q, reply_d;

   logic             frame_rise;
   logic             expired;
   logic             id_valid;
   logic [3:0]       sel_onehot;
   logic [7:0]       reply_byte;

   assign frame_rise = frame & ~frame_q;

   // The timer stops at TIMEOUT, so reaching it is a sticky condition until
   // the state machine leaves TARGET/ROUTE.
   assign expired = (timer_q >= TIMEOUT);

   assign sel_onehot = (4'b0001 << sel_q) & TgtMask;

`ifdef MCU_CMD_SDC_EN
   assign id_valid = (in_data >= 8'd1) && (in_data <= 8'd4);
`else
   assign id_valid = (in_data >= 8'd1) && (in_data <= 8'd3);
   // Reply lane of the absent SDC target is deliberately left unconnected.
   logic unused_sdc_reply;
   assign unused_sdc_reply = ^tgt_reply[31:24];
`endif

   always_comb begin
      reply_byte = 8'h00;
      case (sel_q)
         2'd0:    reply_byte = tgt_reply[7:0];
         2'd1:    reply_byte = tgt_reply[15:8];
         2'd2:    reply_byte = tgt_reply[23:16];
`ifdef MCU_CMD_SDC_EN
         2'd3:    reply_byte = tgt_reply[31:24];
`endif
         default: reply_byte = 8'h00;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      byte_cnt_d = byte_cnt_q;
      timer_d    = timer_q;
      err_d      = err_q;
      strobe_d   = 4'b0000;
      start_d    = 4'b0000;
      data_d     = data_q;
      reply_d    = reply_q;

      // Byte counter and idle timer only run inside an open frame.
      if (state_q != StIdle && in_strobe && byte_cnt_q != 8'hFF) begin
         byte_cnt_d = byte_cnt_q + 8'd1;
      end

      if (state_q == StTarget || state_q == StRoute) begin
         if (in_strobe) begin
            timer_d = 16'd0;
         end else if (!expired) begin
            timer_d = timer_q + 16'd1;
         end
      end

      unique case (state_q)
         StIdle: begin
            byte_cnt_d = 8'd0;
            timer_d    = 16'd0;
            reply_d    = 8'h00;
            if (frame_rise) begin
               state_d = StTarget;
            end
         end

         StTarget: begin
            reply_d = 8'h00;
            if (expired) begin
               state_d = StDiscard;
            end else if (in_strobe) begin
               // Ids 1..4 map to lane 0..3; id 4 wraps to lane 3 via the 2-bit subtract.
               sel_d = in_data[1:0] - 2'd1;
               if (id_valid) begin
                  state_d = StRoute;
               end else begin
                  state_d = StDiscard;
                  if (err_q != ErrMax) begin
                     err_d = err_q + ERR_W'(1);
                  end
               end
            end
         end

         StRoute: begin
            if (expired) begin
               // Abort: a strobe landing on the expiry cycle is dropped too.
               state_d = StDiscard;
               reply_d = 8'h00;
            end else if (in_strobe) begin
               strobe_d = sel_onehot;
               data_d   = in_data;
               reply_d  = reply_byte;
               // Counter is 1 only right after the id byte; once saturated it
               // can never return to 1, so a long frame cannot re-trigger start.
               if (byte_cnt_q == 8'd1) begin
                  start_d = sel_onehot;
               end
            end
         end

         StDiscard: begin
            reply_d = 8'h00;
            timer_d = 16'd0;
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // A strobe on the frame's last cycle is still handled above; the return
      // to idle happens on the following edge.
      if (state_q != StIdle && !frame) begin
         state_d = StIdle;
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         // Treat frame as already high so a frame left open across reset is
         // ignored until it falls and rises again.
         frame_q    <= 1'b1;
         sel_q      <= 2'd0;
         byte_cnt_q <= 8'd0;
         timer_q    <= 16'd0;
         err_q      <= '0;
         strobe_q   <= 4'b0000;
         start_q    <= 4'b0000;
         data_q     <= 8'h00;
         reply_q    <= 8'h00;
      end else begin
         state_q    <= state_d;
         frame_q    <= frame;
         sel_q      <= sel_d;
         byte_cnt_q <= byte_cnt_d;
         timer_q    <= timer_d;
         err_q      <= err_d;
         strobe_q   <= strobe_d;
         start_q    <= start_d;
         data_q     <= data_d;
         reply_q    <= reply_d;
      end
   end

   assign tgt_strobe = strobe_q;
   assign tgt_start  = start_q;
   assign tgt_data   = data_q;
   assign reply_data = reply_q;
   assign busy       = (state_q != StIdle);
   assign err_cnt    = err_q;

endmodule

// File: tb/tb_mcu_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mcu_cmd_ctrl
//
// Drives whole frames (directed and random) into mcu_cmd_ctrl and compares the
// routed byte events, reply bytes, busy and err_cnt against a frame-level
// reference model. Honours MCU_CMD_SDC_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_mcu_cmd_ctrl;

   localparam logic [15:0] Timeout = 16'd100;
   localparam int unsigned ErrW    = 4;
   localparam int          ErrMax  = (1 << ErrW) - 1;
`ifdef MCU_CMD_SDC_EN
   localparam int          NumTgt  = 4;
`else
   localparam int          NumTgt  = 3;
`endif

   logic            clk = 1'b0;
   logic            reset_n;
   logic            frame;
   logic            in_strobe;
   logic [7:0]      in_data;
   logic [3:0]      tgt_strobe;
   logic [3:0]      tgt_start;
   logic [7:0]      tgt_data;
   logic [31:0]     tgt_reply;
   logic [7:0]      reply_data;
   logic            busy;
   logic [ErrW-1:0] err_cnt;

   always #5 clk = ~clk;

   mcu_cmd_ctrl #(
      .TIMEOUT (Timeout),
      .ERR_W   (ErrW)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .frame      (frame),
      .in_strobe  (in_strobe),
      .in_data    (in_data),
      .tgt_strobe (tgt_strobe),
      .tgt_start  (tgt_start),
      .tgt_data   (tgt_data),
      .tgt_reply  (tgt_reply),
      .reply_data (reply_data),
      .busy       (busy),
      .err_cnt    (err_cnt)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Observed routed events: {start, strobe, data}.
   logic [15:0] obs_q[$];

   always @(negedge clk) begin
      if (reset_n === 1'b1 && (tgt_strobe != 4'b0000 || tgt_start != 4'b0000)) begin
         obs_q.push_back({tgt_start, tgt_strobe, tgt_data});
         check_eq("onehot", 32'($onehot0(tgt_strobe) && $onehot0(tgt_start)), 32'd1);
      end
   end

   // Current frame description and model expectations.
   logic [7:0]  fr_bytes[$];
   int          fr_gaps[$];
   logic [15:0] exp_ev[$];
   logic [7:0]  exp_rep[$];
   logic [7:0]  obs_rep[$];
   int          exp_err = 0;

   // Frame-level rules: the id byte picks the target; every later byte is
   // routed until an idle gap of Timeout cycles or more kills the frame.
   task automatic model_frame(input logic [31:0] reply);
      int   id;
      bit   live;
      logic [3:0] sel;
      exp_ev.delete();
      exp_rep.delete();
      id   = int'(fr_bytes[0]);
      live = (fr_gaps[0] < int'(Timeout));
      exp_rep.push_back(8'h00);
      if (live && !(id >= 1 && id <= NumTgt) && exp_err < ErrMax) exp_err++;
      live = live && (id >= 1 && id <= NumTgt);
      sel  = 4'b0000;
      if (live) sel = 4'(1 << (id - 1));
      for (int i = 1; i < fr_bytes.size(); i++) begin
         if (fr_gaps[i] >= int'(Timeout)) live = 1'b0;
         if (live) begin
            exp_ev.push_back({(i == 1) ? sel : 4'b0000, sel, fr_bytes[i]});
            exp_rep.push_back(reply[8*(id-1) +: 8]);
         end else begin
            exp_rep.push_back(8'h00);
         end
      end
   endtask

   task automatic run_frame(input string name, input bit drop_last, input logic [31:0] reply);
      model_frame(reply);
      obs_q.delete();
      obs_rep.delete();
      tgt_reply = reply;
      @(negedge clk);
      frame = 1'b1;
      @(negedge clk);
      check_eq({name, ":busy_open"}, 32'(busy), 32'd1);
      for (int i = 0; i < fr_bytes.size(); i++) begin
         repeat (fr_gaps[i]) @(negedge clk);
         in_strobe = 1'b1;
         in_data   = fr_bytes[i];
         if (drop_last && i == fr_bytes.size() - 1) begin
            frame = 1'b0;
            check_eq({name, ":busy_drop"}, 32'(busy), 32'd1);
         end
         @(negedge clk);
         in_strobe = 1'b0;
         obs_rep.push_back(reply_data);
      end
      if (!drop_last) begin
         repeat (2) @(negedge clk);
         frame = 1'b0;
         check_eq({name, ":busy_fall"}, 32'(busy), 32'd1);
         @(negedge clk);
      end
      check_eq({name, ":busy_idle"}, 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      check_eq({name, ":ev_count"}, 32'(obs_q.size()), 32'(exp_ev.size()));
      for (int i = 0; i < obs_q.size() && i < exp_ev.size(); i++) begin
         check_eq({name, ":ev"}, 32'(obs_q[i]), 32'(exp_ev[i]));
      end
      for (int i = 0; i < obs_rep.size(); i++) begin
         check_eq({name, ":reply"}, 32'(obs_rep[i]), 32'(exp_rep[i]));
      end
      check_eq({name, ":reply_end"}, 32'(reply_data), 32'd0);
      check_eq({name, ":err_cnt"}, 32'(err_cnt), 32'(exp_err));
   endtask

   task automatic set_frame3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int n, input int g1);
      fr_bytes.delete();
      fr_gaps.delete();
      fr_bytes.push_back(b0);
      fr_gaps.push_back(1);
      if (n > 1) begin fr_bytes.push_back(b1); fr_gaps.push_back(g1); end
      if (n > 2) begin fr_bytes.push_back(b2); fr_gaps.push_back(0); end
   endtask

   initial begin
      int n;
      logic [7:0] b;
      int g;
      reset_n   = 1'b0;
      frame     = 1'b0;
      in_strobe = 1'b0;
      in_data   = 8'h00;
      tgt_reply = 32'h0;
      #12;
      check_eq("rst_strobe", 32'(tgt_strobe), 32'd0);
      check_eq("rst_start",  32'(tgt_start),  32'd0);
      check_eq("rst_data",   32'(tgt_data),   32'd0);
      check_eq("rst_reply",  32'(reply_data), 32'd0);
      check_eq("rst_busy",   32'(busy),       32'd0);
      check_eq("rst_err",    32'(err_cnt),    32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed frames.
      set_frame3(8'h02, 8'hA5, 8'h3C, 3, 2);
      run_frame("osd", 1'b0, 32'h44332211);
      set_frame3(8'h07, 8'h11, 8'h22, 3, 0);
      run_frame("unknown", 1'b0, 32'h44332211);
      set_frame3(8'h03, 8'h9C, 8'h00, 2, 0);
      run_frame("sys_reply", 1'b0, 32'hC35A7788);
      set_frame3(8'h01, 8'h55, 8'h00, 2, 100);
      run_frame("tmo_100", 1'b0, 32'h000000AB);
      set_frame3(8'h01, 8'h55, 8'h00, 2, 99);
      run_frame("tmo_99", 1'b0, 32'h000000AB);
      set_frame3(8'h02, 8'h55, 8'h66, 3, 101);
      run_frame("tmo_101", 1'b0, 32'h0000CD00);
      fr_bytes = '{8'h07, 8'h33};
      fr_gaps  = '{100, 0};
      run_frame("tmo_target", 1'b0, 32'h0);
      set_frame3(8'h04, 8'h12, 8'h00, 2, 0);
      run_frame("sdc", 1'b0, 32'hE1000000);
      set_frame3(8'h02, 8'h61, 8'h62, 3, 1);
      run_frame("drop_last", 1'b1, 32'h0000F000);

      // Long frame: byte counter saturates; routing carries on regardless.
      fr_bytes.delete();
      fr_gaps.delete();
      fr_bytes.push_back(8'h02);
      fr_gaps.push_back(0);
      for (int i = 0; i < 299; i++) begin
         fr_bytes.push_back(8'($urandom_range(0, 255)));
         fr_gaps.push_back(0);
      end
      run_frame("long", 1'b0, 32'h00007E00);

      // Random frames.
      for (int f = 0; f < 60; f++) begin
         fr_bytes.delete();
         fr_gaps.delete();
         n = $urandom_range(1, 6);
         for (int k = 0; k < n; k++) begin
            b = 8'($urandom_range(0, 255));
            if (k == 0 && $urandom_range(0, 9) < 8) b = 8'($urandom_range(1, 4));
            g = $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) g = 98 + $urandom_range(0, 3);
            fr_bytes.push_back(b);
            fr_gaps.push_back(g);
         end
         run_frame("rand", ($urandom_range(0, 3) == 0), $urandom());
      end

      // Enough unknown-id frames to pin the counter at all-ones.
      for (int f = 0; f < ErrMax + 3; f++) begin
         set_frame3(8'($urandom_range(5, 255)), 8'h00, 8'h00, 1, 0);
         run_frame("err_sat", 1'b0, 32'h0);
      end

      // Reset in the middle of a routed frame.
      tgt_reply = 32'h000000C4;
      @(negedge clk);
      frame = 1'b1;
      @(negedge clk);
      in_strobe = 1'b1;
      in_data   = 8'h01;
      @(negedge clk);
      in_data   = 8'h77;
      @(negedge clk);
      in_strobe = 1'b0;
      check_eq("pre_rst_strobe", 32'(tgt_strobe), 32'd1);
      check_eq("pre_rst_reply",  32'(reply_data), 32'hC4);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("mid_rst_strobe", 32'(tgt_strobe), 32'd0);
      check_eq("mid_rst_start",  32'(tgt_start),  32'd0);
      check_eq("mid_rst_data",   32'(tgt_data),   32'd0);
      check_eq("mid_rst_reply",  32'(reply_data), 32'd0);
      check_eq("mid_rst_busy",   32'(busy),       32'd0);
      check_eq("mid_rst_err",    32'(err_cnt),    32'd0);
      exp_err = 0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      in_strobe = 1'b1;
      in_data   = 8'h01;
      @(negedge clk);
      in_strobe = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("post_rst_wait", 32'(busy), 32'd0);
      frame = 1'b0;
      repeat (2) @(negedge clk);
      set_frame3(8'h01, 8'hFF, 8'h00, 2, 0);
      run_frame("post_rst", 1'b0, 32'h0000003E);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mcu_cmd_ctrl.md
MCU_CMD_CTRL -- requirements
Module: mcu_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16'd50000: number of idle clk cycles inside an open frame before the frame is aborted.
REQ-002 Parameter ERR_W, default 8: width of the unknown-target error counter.
REQ-003 clk  input  1  core clock; all logic is synchronous to its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 frame  input  1  high while an MCU SPI frame is open (inverted, synchronised chip select).
REQ-006 in_strobe  input  1  one-cycle pulse: a new received byte is valid on in_data.
REQ-007 in_data  input  8  received byte.
REQ-008 tgt_strobe  output  4  one-hot byte strobe; bit0=HID(id 1), bit1=OSD(id 2), bit2=SYS(id 3), bit3=SDC(id 4).
REQ-009 tgt_start  output  4  one-hot pulse on the first byte after the target id (the command byte).
REQ-010 tgt_data  output  8  byte presented to the selected target.
REQ-011 tgt_reply  input  32  reply bytes from the targets; byte n belongs to target bit n.
REQ-012 reply_data  output  8  next byte to be shifted back to the MCU.
REQ-013 busy  output  1  high while state is not IDLE.
REQ-014 err_cnt  output  ERR_W  saturating count of frames with an unknown target id.

Function
REQ-015 States: IDLE, TARGET, ROUTE, DISCARD.
REQ-016 IDLE -> TARGET when frame rises; all other states -> IDLE on the cycle after frame is low.
REQ-017 In TARGET, in_strobe latches in_data as target id; ids 1..4 -> ROUTE; any other id -> DISCARD and err_cnt increments by 1.
REQ-018 err_cnt saturates at all-ones and never wraps.
REQ-019 In ROUTE, each in_strobe produces, one cycle later, a single-cycle pulse on the selected tgt_strobe bit, with tgt_data equal to the byte received.
REQ-020 tgt_start pulses together with tgt_strobe for the first routed byte of the frame only.
REQ-021 In DISCARD, bytes are consumed and no tgt_strobe or tgt_start bit is asserted.
REQ-022 reply_data is registered: on every in_strobe in ROUTE, it loads the tgt_reply byte of the selected target; in IDLE, TARGET and DISCARD it holds 8'h00.
REQ-023 An 8-bit per-frame byte counter saturates at 255 and does not affect routing once saturated.
REQ-024 The idle timer clears on every in_strobe; when it reaches TIMEOUT while frame is high, the state goes to DISCARD until frame falls, and no strobe is issued after that point.
REQ-025 in_strobe coinciding with the falling edge of frame is still processed in the current state; the transition to IDLE follows on the next cycle.
REQ-026 At most one tgt_strobe bit and at most one tgt_start bit are high in any cycle.

Reset
REQ-027 While reset_n is low: state IDLE; tgt_strobe=0, tgt_start=0, tgt_data=8'h00, reply_data=8'h00, busy=0, err_cnt=0; byte counter and timer are 0.
REQ-028 Reset asserted mid-frame aborts the frame immediately; after reset_n is released, the block waits in IDLE for the next rising edge of frame.

Configuration
REQ-029 Macro MCU_CMD_SDC_EN: when defined, target id 4 routes to tgt_strobe[3].
REQ-030 When MCU_CMD_SDC_EN is not defined, id 4 is treated as unknown (DISCARD, err_cnt increments); tgt_strobe[3] and tgt_start[3] are tied 0; tgt_reply[31:24] is ignored.

Verification
REQ-031 Frame with bytes 02,A5,3C -> tgt_start=4'b0010 with data A5, then tgt_strobe=4'b0010 with data 3C; no other bits asserted.
REQ-032 Frame with bytes 07,11,22 -> no tgt_strobe pulses; err_cnt goes 0->1; busy high until one cycle after frame falls.
REQ-033 Frame to id 3 with tgt_reply[23:16]=8'h5A -> reply_data=8'h5A after the first routed byte; 8'h00 after the frame ends.
REQ-034 With TIMEOUT=100, send id 1, then idle 100 cycles, then byte 55 -> no strobe for 55; state DISCARD until frame falls.
REQ-035 Pull reset_n low during ROUTE -> all outputs return to reset values asynchronously; next frame 01,FF -> tgt_start[0] pulses with data FF.
REQ-036 Build without MCU_CMD_SDC_EN, frame 04,12 -> no strobe, err_cnt increments; build with the macro -> tgt_start[3] pulses with data 12.
